// File: rtl/frame_scheduler_pkg.sv
// Shared types and 1024x768@60 VGA timing constants for the vblank task scheduler.
package frame_scheduler_pkg;

    localparam int HOR_TOTAL_TIME       = 1344;
    localparam int VER_TOTAL_TIME       = 806;
    localparam int VER_ACTIVE_TIME      = 768;
    localparam int VER_BLANK_TIME       = VER_TOTAL_TIME - VER_ACTIVE_TIME;
    localparam int VBLANK_CYCLES        = VER_BLANK_TIME * HOR_TOTAL_TIME;
    localparam int DEFAULT_TASK_TIMEOUT = 16384;
    localparam int DEFAULT_NUM_TASKS    = 3;
    localparam int MAX_TASKS            = 8;

    // Worst case of every default task timing out must still fit inside one vblank.
    localparam bit DEFAULT_BUDGET_OK =
        (DEFAULT_NUM_TASKS * DEFAULT_TASK_TIMEOUT) <= VBLANK_CYCLES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } sched_state_t;

    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_scheduler_edge_detect.sv
// Registered rise/fall pulse generator for a synchronous level (vblank, buttons).
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_d_r;
    logic rise_r;
    logic fall_r;

    // Delay the level one cycle and register the edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            level_d_r <= 1'b0;
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
        end else begin
            level_d_r <= level;
            rise_r    <= level & ~level_d_r;
            fall_r    <= ~level & level_d_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/frame_scheduler.sv
// Sequences per-frame game-logic tasks inside vblank, with per-task timeout and
// overrun detection so that no drawn state changes during active video.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int NUM_TASKS      = 3,
    parameter int TIMEOUT_CYCLES = DEFAULT_TASK_TIMEOUT,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   vblnk,
    input  logic [NUM_TASKS-1:0]   task_done,
    input  logic                   clr_flags,
    output logic [NUM_TASKS-1:0]   task_start,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun,
    output logic [NUM_TASKS-1:0]   timeout_flags,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int IDX_W = counter_width(NUM_TASKS);
    localparam int TMO_W = counter_width(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TASKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    generate
        if (NUM_TASKS < 1 || NUM_TASKS > MAX_TASKS) begin : g_bad_num_tasks
            $error("frame_scheduler: NUM_TASKS must be in 1..8");
        end
        if (!DEFAULT_BUDGET_OK) begin : g_bad_budget
            $error("frame_scheduler: default task timeouts exceed the vblank budget");
        end
    endgenerate

    sched_state_t            state_r;
    sched_state_t            state_nxt_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_nxt_s;
    logic [TMO_W-1:0]        tmo_r;
    logic [TMO_W-1:0]        tmo_nxt_s;
    logic                    frame_start_s;
    logic                    vblank_end_s;
    logic                    done_sel_s;
    logic                    last_s;
    logic                    tmo_expired_s;
    logic                    tmo_hit_s;
    logic                    advance_s;
    logic                    overrun_s;
    logic                    cnt_inc_s;
    logic [NUM_TASKS-1:0]    start_nxt_s;
    logic [NUM_TASKS-1:0]    set_flag_s;

    logic [NUM_TASKS-1:0]    task_start_r;
    logic                    busy_r;
    logic                    frame_done_r;
    logic                    overrun_r;
    logic [NUM_TASKS-1:0]    flags_r;
    logic [FRAME_CNT_W-1:0]  frame_cnt_r;

    edge_detect u_vblnk_edge (
        .clk   (clk),
        .rst   (rst),
        .level (vblnk),
        .rise  (frame_start_s),
        .fall  (vblank_end_s)
    );

    // Next-state, task index, timeout counter and pulse decisions
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        tmo_nxt_s     = tmo_r;
        cnt_inc_s     = 1'b0;
        overrun_s     = 1'b0;
        tmo_hit_s     = 1'b0;
        advance_s     = 1'b0;
        done_sel_s    = 1'b0;
        start_nxt_s   = {NUM_TASKS{1'b0}};
        set_flag_s    = {NUM_TASKS{1'b0}};
        last_s        = (idx_r == IDX_LAST);
        tmo_expired_s = (tmo_r == TMO_LAST);

        // Only the done strobe of the task currently being waited on matters
        for (int i = 0; i < NUM_TASKS; i++) begin
            done_sel_s = done_sel_s | (task_done[i] & (idx_r == IDX_W'(i)));
        end

        case (state_r)
            IDLE: begin
                if (frame_start_s && en) begin
                    state_nxt_s = ISSUE;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cnt_inc_s   = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                tmo_nxt_s = {TMO_W{1'b0}};
                if (vblank_end_s) begin
                    state_nxt_s = IDLE;
                    overrun_s   = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                tmo_nxt_s = tmo_r + TMO_W'(1);
                advance_s = done_sel_s | tmo_expired_s;
                tmo_hit_s = ~done_sel_s & tmo_expired_s;
                // Completing the last task beats a coinciding end of vblank
                if (advance_s && last_s) begin
                    state_nxt_s = FINISH;
                end else if (vblank_end_s) begin
                    state_nxt_s = IDLE;
                    overrun_s   = 1'b1;
                end else if (advance_s) begin
                    state_nxt_s = ISSUE;
                    idx_nxt_s   = idx_r + IDX_W'(1);
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            FINISH: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        for (int i = 0; i < NUM_TASKS; i++) begin
            start_nxt_s[i] = (state_nxt_s == ISSUE) & (idx_nxt_s == IDX_W'(i));
            set_flag_s[i]  = tmo_hit_s & (idx_r == IDX_W'(i));
        end
    end

    // State, index and timeout counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            tmo_r   <= {TMO_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            tmo_r   <= tmo_nxt_s;
        end
    end

    // Registered outputs; a new timeout flag takes priority over clr_flags
    always_ff @(posedge clk) begin
        if (rst) begin
            task_start_r <= {NUM_TASKS{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            flags_r      <= {NUM_TASKS{1'b0}};
            frame_cnt_r  <= {FRAME_CNT_W{1'b0}};
        end else begin
            task_start_r <= start_nxt_s;
            busy_r       <= (state_nxt_s == ISSUE) || (state_nxt_s == WAIT);
            frame_done_r <= (state_nxt_s == FINISH);
            overrun_r    <= overrun_s;
            flags_r      <= (clr_flags ? {NUM_TASKS{1'b0}} : flags_r) | set_flag_s;
            frame_cnt_r  <= frame_cnt_r + FRAME_CNT_W'(cnt_inc_s);
        end
    end

    assign task_start    = task_start_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign overrun       = overrun_r;
    assign timeout_flags = flags_r;
    assign frame_cnt     = frame_cnt_r;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: stimulus queues expected output events,
// a monitor compares every start/done/overrun pulse against the queue.
module tb_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       vblnk;
    logic [2:0] task_done = 3'b000;
    logic       clr_flags;
    logic [2:0] task_start;
    logic       busy;
    logic       frame_done;
    logic       overrun;
    logic [2:0] timeout_flags;
    logic [3:0] frame_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int resp_delay[3];
    int cd[3];

    typedef struct {
        string      name;
        int         cyc;
        logic [2:0] ts;
        logic       fd;
        logic       ov;
        logic       busy;
        logic [3:0] fcnt;
        logic [2:0] flags;
    } ev_t;

    ev_t exp_q[$];

    frame_scheduler #(
        .NUM_TASKS      (3),
        .TIMEOUT_CYCLES (16384),
        .FRAME_CNT_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .vblnk         (vblnk),
        .task_done     (task_done),
        .clr_flags     (clr_flags),
        .task_start    (task_start),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .timeout_flags (timeout_flags),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Task model: answers done resp_delay cycles after its start (0 = never answers)
    always @(negedge clk) begin
        logic [2:0] d;
        d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cd[i] = 0;
            end else begin
                if (cd[i] > 0) begin
                    cd[i] = cd[i] - 1;
                    if (cd[i] == 0) d[i] = 1'b1;
                end
                if (task_start[i] && resp_delay[i] > 0) cd[i] = resp_delay[i];
            end
        end
        task_done = d;
    end

    // Monitor: every output pulse must match the head of the expected queue
    always @(negedge clk) begin
        ev_t e;
        if (task_start != 3'b000 || frame_done || overrun) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got cyc=%0d ts=%b fd=%b ov=%b, want no event",
                         cyc, task_start, frame_done, overrun);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || task_start !== e.ts || frame_done !== e.fd ||
                    overrun !== e.ov || busy !== e.busy || frame_cnt !== e.fcnt ||
                    timeout_flags !== e.flags) begin
                    miscompares++;
                    $display("FAIL %s: got cyc=%0d ts=%b fd=%b ov=%b busy=%b cnt=%h flags=%b, want cyc=%0d ts=%b fd=%b ov=%b busy=%b cnt=%h flags=%b",
                             e.name, cyc, task_start, frame_done, overrun, busy, frame_cnt,
                             timeout_flags, e.cyc, e.ts, e.fd, e.ov, e.busy, e.fcnt, e.flags);
                end
            end
        end
    end

    task automatic push(input string name, input int c, input logic [2:0] ts,
                        input logic fd, input logic ov, input logic b,
                        input logic [3:0] fcnt, input logic [2:0] flags);
        ev_t e;
        e.name = name; e.cyc = c; e.ts = ts; e.fd = fd; e.ov = ov;
        e.busy = b; e.fcnt = fcnt; e.flags = flags;
        exp_q.push_back(e);
    endtask

    // Nominal three-task frame started by a rise presented at cycle k
    task automatic push_frame(input string name, input int k, input int d,
                              input logic [3:0] fcnt, input logic [2:0] flags);
        push({name, "_t0"}, k + 2,                 3'b001, 1'b0, 1'b0, 1'b1, fcnt, flags);
        push({name, "_t1"}, k + 3 + d,             3'b010, 1'b0, 1'b0, 1'b1, fcnt, flags);
        push({name, "_t2"}, k + 4 + 2 * d,         3'b100, 1'b0, 1'b0, 1'b1, fcnt, flags);
        push({name, "_fd"}, k + 5 + 3 * d,         3'b000, 1'b1, 1'b0, 1'b0, fcnt, flags);
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    initial begin
        int k;
        int base;
        rst = 1'b1; en = 1'b0; vblnk = 1'b0; clr_flags = 1'b0;
        resp_delay = '{10, 10, 10};
        @(negedge clk);

        // Reset for three cycles
        at(3);
        rst = 1'b0;
        check("reset_state", 32'({task_start, busy, frame_done, overrun, timeout_flags, frame_cnt}), 32'd0);

        // Nominal frame
        k = 10;
        at(k); en = 1'b1; vblnk = 1'b1;
        push_frame("nominal", k, 10, 4'd1, 3'b000);
        at(k + 50); vblnk = 1'b0;

        // Task 1 times out; clr_flags coinciding with the set must lose
        k = 100;
        resp_delay[1] = 0;
        at(k); vblnk = 1'b1;
        push("tmo_t0", k + 2,     3'b001, 1'b0, 1'b0, 1'b1, 4'd2, 3'b000);
        push("tmo_t1", k + 13,    3'b010, 1'b0, 1'b0, 1'b1, 4'd2, 3'b000);
        push("tmo_t2", k + 16398, 3'b100, 1'b0, 1'b0, 1'b1, 4'd2, 3'b010);
        push("tmo_fd", k + 16409, 3'b000, 1'b1, 1'b0, 1'b0, 4'd2, 3'b010);
        at(k + 16396);
        check("tmo_not_early", 32'(timeout_flags), 32'd0);
        at(k + 16397); clr_flags = 1'b1;
        at(k + 16398); clr_flags = 1'b0;
        at(k + 16420); vblnk = 1'b0; clr_flags = 1'b1; resp_delay[1] = 10;
        at(k + 16421); clr_flags = 1'b0;
        at(k + 16422);
        check("clr_flags", 32'(timeout_flags), 32'd0);

        // Task 2 held off, vblank ends 500 cycles after its start
        k = 16600;
        resp_delay[2] = 0;
        at(k); vblnk = 1'b1;
        push("ovr_t0", k + 2,   3'b001, 1'b0, 1'b0, 1'b1, 4'd3, 3'b000);
        push("ovr_t1", k + 13,  3'b010, 1'b0, 1'b0, 1'b1, 4'd3, 3'b000);
        push("ovr_t2", k + 24,  3'b100, 1'b0, 1'b0, 1'b1, 4'd3, 3'b000);
        push("ovr_pulse", k + 526, 3'b000, 1'b0, 1'b1, 1'b0, 4'd3, 3'b000);
        at(k + 524); vblnk = 1'b0;
        at(k + 540); resp_delay[2] = 10;
        check("ovr_idle_busy", 32'(busy), 32'd0);

        // Next frame restarts at task 0
        k = 17200;
        at(k); vblnk = 1'b1;
        push_frame("restart", k, 10, 4'd4, 3'b000);
        at(k + 50); vblnk = 1'b0;

        // Last done coincides with detected vblank end: completion wins
        k = 17300;
        at(k); vblnk = 1'b1;
        push_frame("coinc", k, 10, 4'd5, 3'b000);
        at(k + 33); vblnk = 1'b0;

        // en low at frame start: ignored
        k = 17400;
        at(k); en = 1'b0; vblnk = 1'b1;
        at(k + 40);
        check("gated_cnt", 32'(frame_cnt), 32'd5);
        vblnk = 1'b0;

        // en dropped mid-sequence: frame still completes
        k = 17500;
        at(k); en = 1'b1; vblnk = 1'b1;
        push_frame("en_drop", k, 10, 4'd6, 3'b000);
        at(k + 5); en = 1'b0;
        at(k + 50); vblnk = 1'b0; en = 1'b1;

        // Reset during WAIT clears everything with no pulses
        k = 17600;
        resp_delay[0] = 0;
        at(k); vblnk = 1'b1;
        push("rst_t0", k + 2, 3'b001, 1'b0, 1'b0, 1'b1, 4'd7, 3'b000);
        at(k + 20); rst = 1'b1; vblnk = 1'b0;
        at(k + 21); rst = 1'b0;
        check("rst_mid_wait", 32'({task_start, busy, frame_done, overrun, timeout_flags, frame_cnt}), 32'd0);
        at(k + 30);
        check("rst_stays_idle", 32'(busy), 32'd0);

        // Sixteen short frames wrap the 4-bit frame counter through 0xF to 0x0
        resp_delay = '{1, 1, 1};
        base = 17700;
        for (int f = 0; f < 16; f++) begin
            at(base + f * 20); vblnk = 1'b1;
            push_frame("wrap", base + f * 20, 1, 4'(f + 1), 3'b000);
            at(base + f * 20 + 10); vblnk = 1'b0;
        end
        at(base + 16 * 20 + 10);
        check("wrap_cnt", 32'(frame_cnt), 32'd0);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: got no event, want event at cyc=%0d", e.name, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
